seq_monitor: RTL

Downstream checker for the 6-bit prime/Fibonacci sequence counter.
- Samples the counter's output word and its control inputs (`en`, `seq`, `ud`) every clock and verifies that each new value is the legal successor of the previous one.
- Reports errors, wrap-arounds and lock status to the test/status logic.
- Purely observational: it never drives the counter.

---
 rtl/seq_monitor.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_monitor.sv
// seq_monitor: passive checker for the 6-bit prime/Fibonacci sequence counter.
// Verifies every sample is the legal successor of the previous one and reports errors, wraps and lock.
module seq_monitor #(
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              seq,
  input  logic              ud,
  input  logic [5:0]        cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic              wrap_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [STEP_W-1:0] step_cnt,
  output logic [5:0]        first_err
);

  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, SYNC, TRACK} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       prev_cnt;
  logic                prev_en;
  logic [1:0]          prev_mode;

  logic [CW+1:0]       prev_lu;
  logic [CW-1:0]       expected;
  logic                exp_valid;
  logic                err, step_ok, wrap;
  logic [ERR_W-1:0]    err_base, err_cnt_next;
  logic [STEP_W-1:0]   step_base, step_cnt_next;
  logic                sticky_base, sticky_next;
  logic [CW-1:0]       first_err_next;

  function automatic logic in_set(input logic [CW-1:0] v, input logic fib);
    if (fib)
      return v inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 6'd34, 6'd55};
    return v inside {6'd2, 6'd3, 6'd5, 6'd7, 6'd11, 6'd13, 6'd17, 6'd19, 6'd23, 6'd29, 6'd31};
  endfunction

  // Successor decode: returns {member, wrap, next}.
  function automatic logic [CW+1:0] lookup(input logic [CW-1:0] v, input logic fib,
                                           input logic down);
    logic [CW-1:0] up_v, dn_v;
    logic          wr;
    up_v = '0;
    dn_v = '0;
    wr   = 1'b0;
    if (!fib) begin
      case (v)
        6'd2:    begin up_v = 6'd3;  dn_v = 6'd31; wr = down;  end
        6'd3:    begin up_v = 6'd5;  dn_v = 6'd2;  end
        6'd5:    begin up_v = 6'd7;  dn_v = 6'd3;  end
        6'd7:    begin up_v = 6'd11; dn_v = 6'd5;  end
        6'd11:   begin up_v = 6'd13; dn_v = 6'd7;  end
        6'd13:   begin up_v = 6'd17; dn_v = 6'd11; end
        6'd17:   begin up_v = 6'd19; dn_v = 6'd13; end
        6'd19:   begin up_v = 6'd23; dn_v = 6'd17; end
        6'd23:   begin up_v = 6'd29; dn_v = 6'd19; end
        6'd29:   begin up_v = 6'd31; dn_v = 6'd23; end
        6'd31:   begin up_v = 6'd2;  dn_v = 6'd29; wr = ~down; end
        default: ;
      endcase
    end else begin
      case (v)
        6'd0:    begin up_v = 6'd1;  dn_v = 6'd55; wr = down;  end
        6'd1:    begin up_v = 6'd2;  dn_v = 6'd0;  end
        6'd2:    begin up_v = 6'd3;  dn_v = 6'd1;  end
        6'd3:    begin up_v = 6'd5;  dn_v = 6'd2;  end
        6'd5:    begin up_v = 6'd8;  dn_v = 6'd3;  end
        6'd8:    begin up_v = 6'd13; dn_v = 6'd5;  end
        6'd13:   begin up_v = 6'd21; dn_v = 6'd8;  end
        6'd21:   begin up_v = 6'd34; dn_v = 6'd13; end
        6'd34:   begin up_v = 6'd55; dn_v = 6'd21; end
        6'd55:   begin up_v = 6'd0;  dn_v = 6'd34; wr = ~down; end
        default: ;
      endcase
    end
    return {in_set(v, fib), wr, (down ? dn_v : up_v)};
  endfunction

  // Next state, check result and next counter values.
  always_comb begin
    state_next = state;
    err        = 1'b0;
    step_ok    = 1'b0;
    wrap       = 1'b0;
    prev_lu    = lookup(prev_cnt, prev_mode[1], prev_mode[0]);
    expected   = prev_en ? prev_lu[CW-1:0] : prev_cnt;
    exp_valid  = !prev_en || prev_lu[CW+1];

    case (state)
      IDLE: if (en) state_next = SYNC;
      SYNC: begin
        if (!en)                  state_next = IDLE;
        else if (!in_set(cnt, seq)) err      = 1'b1;
        else                      state_next = TRACK;
      end
      TRACK: begin
        if ({seq, ud} != prev_mode) begin
          state_next = SYNC;
        end else if (!exp_valid || cnt != expected) begin
          err        = 1'b1;
          state_next = SYNC;
        end else begin
          step_ok = prev_en;
          wrap    = prev_en & prev_lu[CW];
          if (!en && !prev_en) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // clr empties the counters first so a coincident error is still counted.
    err_base       = clr ? '0 : err_cnt;
    step_base      = clr ? '0 : step_cnt;
    sticky_base    = clr ? 1'b0 : err_sticky;
    err_cnt_next   = (err && err_base != '1) ? err_base + ERR_W'(1) : err_base;
    step_cnt_next  = (step_ok && step_base != '1) ? step_base + STEP_W'(1) : step_base;
    sticky_next    = sticky_base | err;
    first_err_next = (err && !sticky_base) ? cnt : (clr ? '0 : first_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_cnt   <= '0;
      prev_en    <= 1'b0;
      prev_mode  <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      wrap_pulse <= 1'b0;
      err_cnt    <= '0;
      step_cnt   <= '0;
      first_err  <= '0;
    end else begin
      state      <= state_next;
      prev_cnt   <= cnt;
      prev_en    <= en;
      prev_mode  <= {seq, ud};
      locked     <= (state_next == TRACK);
      err_pulse  <= err;
      err_sticky <= sticky_next;
      wrap_pulse <= wrap;
      err_cnt    <= err_cnt_next;
      step_cnt   <= step_cnt_next;
      first_err  <= first_err_next;
    end
  end

endmodule
